// File: rtl/axi4_frame_reader_if.sv
// Bundles the AXI4 read channels of the frame reader together with its downstream
// stream port so that a single interface connects the reader to memory and FIFO.
interface axi4_frame_reader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic [3:0]        ARCACHE;
    logic [2:0]        ARPROT;

    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT,
        output RREADY, m_data, m_valid,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID, m_ready
    );

    modport slave (
        input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT,
        input  RREADY, m_data, m_valid,
        output ARREADY, RDATA, RRESP, RLAST, RVALID, m_ready
    );
endinterface

// File: rtl/axi4_frame_reader.sv
// AXI4 read master that streams one stored frame out of DDR per frame-start edge,
// using fixed-length INCR bursts and forwarding each beat straight to the output FIFO.
module axi4_frame_reader #(
    parameter int                        AXI_ADDR_WIDTH   = 32,
    parameter int                        AXI_DATA_WIDTH   = 64,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR  = 32'h0100_0000,
    parameter int                        BURST_LEN        = 64,
    parameter int                        BURST_BYTES      = BURST_LEN * (AXI_DATA_WIDTH / 8),
    parameter int                        BURSTS_PER_FRAME = 300
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst_n,
    input  logic                      i_frame_start,
    input  logic                      i_space_ok,
    axi4_frame_reader_if.master       bus,
    output logic                      o_frame_done,
    output logic                      o_rresp_err,
    output logic                      o_rlast_err,
    output logic [1:0]                state,
    output logic [AXI_ADDR_WIDTH-1:0] ADDR_OFFSET
);

    localparam int BEAT_W  = $clog2(BURST_LEN);
    localparam int BURST_W = $clog2(BURSTS_PER_FRAME + 1);

    localparam logic [BEAT_W-1:0]         LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0]        LAST_BURST  = BURST_W'(BURSTS_PER_FRAME - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] OFFSET_STEP = AXI_ADDR_WIDTH'(BURST_BYTES);
    localparam logic [2:0]                AXSIZE      = 3'($clog2(AXI_DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        ADDR_SEND  = 2'd2,
        DATA_RECV  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic                      start_d1_q, start_d1_d;
    logic                      arvalid_q, arvalid_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [AXI_ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [BURST_W-1:0]        burst_q, burst_d;
    logic                      done_q, done_d;
    logic                      rresp_err_q, rresp_err_d;
    logic                      rlast_err_q, rlast_err_d;

    logic start_edge;
    logic ar_fire;
    logic r_fire;
    logic last_beat;
    logic last_burst;
    logic rready;
    logic mvalid;

    assign start_edge = i_frame_start & ~start_d1_q;
    assign ar_fire    = (state_q == ADDR_SEND) & arvalid_q & bus.ARREADY;
    assign r_fire     = (state_q == DATA_RECV) & bus.RVALID & bus.m_ready;
    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (burst_q == LAST_BURST);

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start edges are only honoured in IDLE, so a request arriving mid-frame is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start_edge) state_d = WAIT_SPACE;
            WAIT_SPACE: if (i_space_ok) state_d = ADDR_SEND;
            ADDR_SEND:  if (ar_fire)    state_d = DATA_RECV;
            DATA_RECV: begin
                if (r_fire && last_beat) begin
                    state_d = last_burst ? IDLE : WAIT_SPACE;
                end
            end
            default:    state_d = IDLE;
        endcase
    end

    // The read data path is a pure wire; backpressure from the FIFO goes straight to RREADY.
    always_comb begin
        rready = 1'b0;
        mvalid = 1'b0;
        case (state_q)
            DATA_RECV: begin
                rready = bus.m_ready;
                mvalid = bus.RVALID;
            end
            default: begin
                rready = 1'b0;
                mvalid = 1'b0;
            end
        endcase
    end

    always_comb begin
        start_d1_d  = i_frame_start;
        arvalid_d   = (state_d == ADDR_SEND);
        araddr_d    = araddr_q;
        offset_d    = offset_q;
        beat_d      = beat_q;
        burst_d     = burst_q;
        done_d      = 1'b0;
        rresp_err_d = rresp_err_q;
        rlast_err_d = rlast_err_q;

        if ((state_q == IDLE) && start_edge) begin
            offset_d    = '0;
            burst_d     = '0;
            beat_d      = '0;
            rresp_err_d = 1'b0;
            rlast_err_d = 1'b0;
        end

        if ((state_q == WAIT_SPACE) && i_space_ok) begin
            araddr_d = FRAME_BASE_ADDR + offset_q;
        end

        // The burst length is fixed by the beat counter; RLAST is only checked, never obeyed.
        if (r_fire) begin
            if (bus.RRESP != 2'b00) rresp_err_d = 1'b1;
            if (bus.RLAST != last_beat) rlast_err_d = 1'b1;
            if (last_beat) begin
                beat_d   = '0;
                offset_d = offset_q + OFFSET_STEP;
                burst_d  = burst_q + BURST_W'(1);
                done_d   = last_burst;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            start_d1_q  <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= FRAME_BASE_ADDR;
            offset_q    <= '0;
            beat_q      <= '0;
            burst_q     <= '0;
            done_q      <= 1'b0;
            rresp_err_q <= 1'b0;
            rlast_err_q <= 1'b0;
        end else begin
            start_d1_q  <= start_d1_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            offset_q    <= offset_d;
            beat_q      <= beat_d;
            burst_q     <= burst_d;
            done_q      <= done_d;
            rresp_err_q <= rresp_err_d;
            rlast_err_q <= rlast_err_d;
        end
    end

    assign bus.ARADDR  = araddr_q;
    assign bus.ARVALID = arvalid_q;
    assign bus.ARLEN   = 8'(BURST_LEN - 1);
    assign bus.ARSIZE  = AXSIZE;
    assign bus.ARBURST = 2'b01;
    assign bus.ARCACHE = 4'b1111;
    assign bus.ARPROT  = 3'b010;
    assign bus.RREADY  = rready;
    assign bus.m_valid = mvalid;
    assign bus.m_data  = bus.RDATA;

    assign o_frame_done = done_q;
    assign o_rresp_err  = rresp_err_q;
    assign o_rlast_err  = rlast_err_q;
    assign state        = state_q;
    assign ADDR_OFFSET  = offset_q;

endmodule

// File: tb/tb_axi4_frame_reader.sv
// Directed bench for axi4_frame_reader: a reactive DDR slave returns address-tagged words
// so every forwarded word, burst address and handshake can be checked against the frame layout.
`timescale 1ns/1ps
module tb_axi4_frame_reader;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk_100Mhz = 1'b0;
    logic        rst_n;
    logic        i_frame_start;
    logic        i_space_ok;
    logic        o_frame_done;
    logic        o_rresp_err;
    logic        o_rlast_err;
    logic [1:0]  state;
    logic [31:0] ADDR_OFFSET;

    axi4_frame_reader_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    axi4_frame_reader dut (
        .clk_100Mhz   (clk_100Mhz),
        .rst_n        (rst_n),
        .i_frame_start(i_frame_start),
        .i_space_ok   (i_space_ok),
        .bus          (bus),
        .o_frame_done (o_frame_done),
        .o_rresp_err  (o_rresp_err),
        .o_rlast_err  (o_rlast_err),
        .state        (state),
        .ADDR_OFFSET  (ADDR_OFFSET)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    int checks   = 0;
    int failures = 0;

    int arDelay     = 0;
    bit randomReady = 1'b0;
    int injectBurst = -1;

    int arCount      = 0;
    int wordCount    = 0;
    int arHighCycles = 0;
    int doneCount    = 0;
    int addrErr      = 0;
    int dataErr      = 0;
    int mirrorErr    = 0;
    int arStableErr  = 0;
    int doneErr      = 0;
    logic [31:0] lastArAddr = '0;

    // Memory slave and monitor: observe at negedge, drive the next cycle just after posedge.
    initial begin : slave
        bit          busy, arHs, rHs, arPending;
        int          beat, waitCnt, curBurst;
        logic [31:0] curAddr, heldAddr, expAddr;
        busy = 0; arPending = 0; beat = 0; waitCnt = 0; curBurst = 0;
        curAddr = '0; heldAddr = '0;
        bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0;
        bus.RRESP = 2'b00; bus.RLAST = 1'b0; bus.m_ready = 1'b1;
        forever begin
            @(negedge clk_100Mhz);
            arHs = 0;
            rHs  = 0;
            if (rst_n === 1'b1) begin
                arHs = bus.ARVALID && bus.ARREADY;
                rHs  = bus.RVALID && bus.RREADY;
                if (busy) begin
                    if (bus.RREADY !== bus.m_ready || bus.m_valid !== bus.RVALID || bus.m_data !== bus.RDATA)
                        mirrorErr++;
                end else if (bus.RREADY !== 1'b0 || bus.m_valid !== 1'b0) begin
                    mirrorErr++;
                end
                if (bus.ARVALID === 1'b1) arHighCycles++;
                if (arPending && (bus.ARVALID !== 1'b1 || bus.ARADDR !== heldAddr)) arStableErr++;
                arPending = (bus.ARVALID === 1'b1) && (bus.ARREADY !== 1'b1);
                heldAddr  = bus.ARADDR;
                if (arHs) begin
                    expAddr = BASE + 32'((arCount % 300) * 512);
                    if (bus.ARADDR !== expAddr || bus.ARLEN !== 8'd63 || bus.ARSIZE !== 3'b011 ||
                        bus.ARBURST !== 2'b01 || bus.ARCACHE !== 4'b1111 || bus.ARPROT !== 3'b010)
                        addrErr++;
                    curBurst   = arCount % 300;
                    lastArAddr = bus.ARADDR;
                    arCount++;
                end
                if (rHs) begin
                    expAddr = BASE + 32'((wordCount % 19200) * 8);
                    if (bus.m_data !== {expAddr, ~expAddr}) dataErr++;
                    wordCount++;
                end
                if (o_frame_done === 1'b1) begin
                    doneCount++;
                    if (wordCount == 0 || (wordCount % 19200) != 0) doneErr++;
                end
            end
            @(posedge clk_100Mhz);
            #1;
            if (rst_n !== 1'b1) begin
                busy = 0; beat = 0; waitCnt = 0; arPending = 0;
                arCount = 0; wordCount = 0;
                bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RRESP = 2'b00;
            end else begin
                if (rHs) begin
                    beat++;
                    if (beat == 64) begin
                        busy = 0;
                        beat = 0;
                    end
                end
                if (arHs) begin
                    busy    = 1;
                    beat    = 0;
                    curAddr = lastArAddr;
                end
                if (arDelay == 0) begin
                    bus.ARREADY = 1'b1;
                end else if (bus.ARVALID === 1'b1) begin
                    bus.ARREADY = (waitCnt >= arDelay);
                    waitCnt++;
                end else begin
                    bus.ARREADY = 1'b0;
                    waitCnt = 0;
                end
                bus.RVALID = busy;
                expAddr    = curAddr + 32'(beat * 8);
                bus.RDATA  = {expAddr, ~expAddr};
                bus.RLAST  = busy && (beat == 63 || (curBurst == injectBurst && beat == 10));
                bus.RRESP  = (busy && curBurst == injectBurst && beat == 20) ? 2'b10 : 2'b00;
                bus.m_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic doReset();
        @(posedge clk_100Mhz);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk_100Mhz);
        #3 rst_n = 1'b1;
    endtask

    task automatic pulseStart();
        @(posedge clk_100Mhz);
        #1 i_frame_start = 1'b1;
        @(posedge clk_100Mhz);
        #1 i_frame_start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_100Mhz);
        #1;
        checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
        checks++; if (bus.ARVALID !== 1'b0) begin failures++; $display("[TB] FAIL reset_arvalid got=%b exp=0", bus.ARVALID); end
        checks++; if (bus.ARADDR !== BASE) begin failures++; $display("[TB] FAIL reset_araddr got=%h exp=%h", bus.ARADDR, BASE); end
        checks++; if (ADDR_OFFSET !== 32'd0) begin failures++; $display("[TB] FAIL reset_offset got=%h exp=0", ADDR_OFFSET); end
        checks++; if ({o_frame_done, o_rresp_err, o_rlast_err} !== 3'b000) begin
            failures++; $display("[TB] FAIL reset_flags got=%b exp=000", {o_frame_done, o_rresp_err, o_rlast_err}); end
        checks++; if ({bus.RREADY, bus.m_valid} !== 2'b00) begin
            failures++; $display("[TB] FAIL reset_rready_mvalid got=%b exp=00", {bus.RREADY, bus.m_valid}); end
        @(posedge clk_100Mhz);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        int doneBefore;
        doneBefore = doneCount;
        pulseStart();
        for (int i = 0; i < 400 && arCount < 3; i++) begin @(negedge clk_100Mhz); #1; end
        pulseStart();
        for (int i = 0; i < 25000 && doneCount == doneBefore; i++) begin @(negedge clk_100Mhz); #1; end
        checks++; if (doneCount == doneBefore) begin failures++; $display("[TB] FAIL frame_done_timeout got=0 exp=1"); end
        repeat (30) begin @(negedge clk_100Mhz); #1; end
        checks++; if (arCount !== 300) begin failures++; $display("[TB] FAIL full_ar_count got=%0d exp=300", arCount); end
        checks++; if (wordCount !== 19200) begin failures++; $display("[TB] FAIL full_word_count got=%0d exp=19200", wordCount); end
        checks++; if (doneCount - doneBefore !== 1) begin failures++; $display("[TB] FAIL full_done_pulses got=%0d exp=1", doneCount - doneBefore); end
        checks++; if (lastArAddr !== 32'h0102_5600) begin failures++; $display("[TB] FAIL full_last_araddr got=%h exp=01025600", lastArAddr); end
        checks++; if (addrErr !== 0) begin failures++; $display("[TB] FAIL full_ar_errors got=%0d exp=0", addrErr); end
        checks++; if (dataErr !== 0) begin failures++; $display("[TB] FAIL full_data_errors got=%0d exp=0", dataErr); end
        checks++; if (mirrorErr !== 0) begin failures++; $display("[TB] FAIL full_rready_mirror got=%0d exp=0", mirrorErr); end
        checks++; if (doneErr !== 0) begin failures++; $display("[TB] FAIL full_done_position got=%0d exp=0", doneErr); end
        checks++; if ({o_rresp_err, o_rlast_err} !== 2'b00) begin
            failures++; $display("[TB] FAIL full_err_flags got=%b exp=00", {o_rresp_err, o_rlast_err}); end
        checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL full_end_state got=%0d exp=0", state); end
        checks++; if (ADDR_OFFSET !== 32'h0002_5800) begin failures++; $display("[TB] FAIL full_end_offset got=%h exp=00025800", ADDR_OFFSET); end
    endtask

    task automatic test_backpressure();
        int doneBefore, arStart, wordStart;
        doneBefore = doneCount;
        arStart = arCount;
        wordStart = wordCount;
        randomReady = 1'b1;
        injectBurst = 3;
        pulseStart();
        for (int i = 0; i < 1000 && arCount < arStart + 3; i++) begin @(negedge clk_100Mhz); #1; end
        checks++; if ({o_rresp_err, o_rlast_err} !== 2'b00) begin
            failures++; $display("[TB] FAIL bp_flags_before_inject got=%b exp=00", {o_rresp_err, o_rlast_err}); end
        for (int i = 0; i < 50000 && doneCount == doneBefore; i++) begin @(negedge clk_100Mhz); #1; end
        checks++; if (doneCount == doneBefore) begin failures++; $display("[TB] FAIL bp_frame_timeout got=0 exp=1"); end
        randomReady = 1'b0;
        injectBurst = -1;
        checks++; if (wordCount - wordStart !== 19200) begin failures++; $display("[TB] FAIL bp_word_count got=%0d exp=19200", wordCount - wordStart); end
        checks++; if (arCount - arStart !== 300) begin failures++; $display("[TB] FAIL bp_ar_count got=%0d exp=300", arCount - arStart); end
        checks++; if (dataErr !== 0) begin failures++; $display("[TB] FAIL bp_data_errors got=%0d exp=0", dataErr); end
        checks++; if (mirrorErr !== 0) begin failures++; $display("[TB] FAIL bp_rready_mirror got=%0d exp=0", mirrorErr); end
        checks++; if (addrErr !== 0) begin failures++; $display("[TB] FAIL bp_ar_errors got=%0d exp=0", addrErr); end
    endtask

    task automatic test_error_flags();
        checks++; if (o_rresp_err !== 1'b1) begin failures++; $display("[TB] FAIL err_rresp_sticky got=%b exp=1", o_rresp_err); end
        checks++; if (o_rlast_err !== 1'b1) begin failures++; $display("[TB] FAIL err_rlast_sticky got=%b exp=1", o_rlast_err); end
        pulseStart();
        repeat (2) begin @(negedge clk_100Mhz); #1; end
        checks++; if ({o_rresp_err, o_rlast_err} !== 2'b00) begin
            failures++; $display("[TB] FAIL err_cleared_by_start got=%b exp=00", {o_rresp_err, o_rlast_err}); end
        checks++; if (ADDR_OFFSET !== 32'd0) begin failures++; $display("[TB] FAIL err_offset_restart got=%h exp=0", ADDR_OFFSET); end
        doReset();
    endtask

    task automatic test_space_stall();
        int arH0;
        doReset();
        pulseStart();
        for (int i = 0; i < 1000 && wordCount < 4 * 64 + 5; i++) begin @(negedge clk_100Mhz); #1; end
        @(posedge clk_100Mhz);
        #1 i_space_ok = 1'b0;
        for (int i = 0; i < 200 && wordCount < 320; i++) begin @(negedge clk_100Mhz); #1; end
        arH0 = arHighCycles;
        repeat (100) begin @(negedge clk_100Mhz); #1; end
        checks++; if (arHighCycles !== arH0) begin failures++; $display("[TB] FAIL stall_arvalid_cycles got=%0d exp=0", arHighCycles - arH0); end
        checks++; if (arCount !== 5) begin failures++; $display("[TB] FAIL stall_ar_count got=%0d exp=5", arCount); end
        checks++; if (state !== 2'd1) begin failures++; $display("[TB] FAIL stall_state got=%0d exp=1", state); end
        @(posedge clk_100Mhz);
        #1 i_space_ok = 1'b1;
        @(negedge clk_100Mhz);
        #1;
        checks++; if (bus.ARVALID !== 1'b0) begin failures++; $display("[TB] FAIL stall_arvalid_early got=%b exp=0", bus.ARVALID); end
        @(negedge clk_100Mhz);
        #1;
        checks++; if (bus.ARVALID !== 1'b1 || bus.ARADDR !== 32'h0100_0A00) begin
            failures++; $display("[TB] FAIL stall_burst5_issue got=%b/%h exp=1/01000a00", bus.ARVALID, bus.ARADDR); end
        doReset();
    endtask

    task automatic test_arready_delay();
        int arH0;
        doReset();
        arDelay = 7;
        arH0 = arHighCycles;
        pulseStart();
        for (int i = 0; i < 50 && arCount < 1; i++) begin @(negedge clk_100Mhz); #1; end
        checks++; if (arHighCycles - arH0 !== 8) begin failures++; $display("[TB] FAIL ardelay_valid_cycles got=%0d exp=8", arHighCycles - arH0); end
        repeat (20) begin @(negedge clk_100Mhz); #1; end
        checks++; if (arCount !== 1) begin failures++; $display("[TB] FAIL ardelay_handshakes got=%0d exp=1", arCount); end
        checks++; if (arStableErr !== 0) begin failures++; $display("[TB] FAIL ardelay_stability got=%0d exp=0", arStableErr); end
        checks++; if (addrErr !== 0) begin failures++; $display("[TB] FAIL ardelay_ar_errors got=%0d exp=0", addrErr); end
        arDelay = 0;
        doReset();
    endtask

    task automatic test_reset_mid_burst();
        doReset();
        pulseStart();
        for (int i = 0; i < 4000 && wordCount < 40 * 64 + 20; i++) begin @(negedge clk_100Mhz); #1; end
        checks++; if (arCount !== 41) begin failures++; $display("[TB] FAIL midrst_burst_index got=%0d exp=41", arCount); end
        @(posedge clk_100Mhz);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL midrst_state got=%0d exp=0", state); end
        checks++; if (bus.ARADDR !== BASE || ADDR_OFFSET !== 32'd0) begin
            failures++; $display("[TB] FAIL midrst_addr got=%h/%h exp=%h/0", bus.ARADDR, ADDR_OFFSET, BASE); end
        checks++; if ({bus.ARVALID, bus.RREADY, bus.m_valid, o_frame_done, o_rresp_err, o_rlast_err} !== 6'b0) begin
            failures++; $display("[TB] FAIL midrst_outputs got=%b exp=000000",
                {bus.ARVALID, bus.RREADY, bus.m_valid, o_frame_done, o_rresp_err, o_rlast_err}); end
        repeat (4) @(posedge clk_100Mhz);
        #3;
        checks++; if ({bus.ARVALID, bus.RREADY} !== 2'b00) begin
            failures++; $display("[TB] FAIL midrst_held got=%b exp=00", {bus.ARVALID, bus.RREADY}); end
        rst_n = 1'b1;
        pulseStart();
        for (int i = 0; i < 50 && arCount < 1; i++) begin @(negedge clk_100Mhz); #1; end
        checks++; if (arCount < 1 || lastArAddr !== BASE) begin
            failures++; $display("[TB] FAIL midrst_restart_addr got=%h exp=%h", lastArAddr, BASE); end
        for (int i = 0; i < 400 && wordCount < 128; i++) begin @(negedge clk_100Mhz); #1; end
        checks++; if (wordCount < 128 || dataErr !== 0 || mirrorErr !== 0 || addrErr !== 0) begin
            failures++; $display("[TB] FAIL midrst_restart_data got=%0d words/%0d errs exp=128/0",
                wordCount, dataErr + mirrorErr + addrErr); end
        doReset();
    endtask

    initial begin
        rst_n         = 1'b0;
        i_frame_start = 1'b0;
        i_space_ok    = 1'b1;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_error_flags();
        test_space_stall();
        test_arready_delay();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
